// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
package lsu_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'b00,
      CAUSE_MISALIGN = 2'b01,
      CAUSE_ILLEGAL  = 2'b10,
      CAUSE_TIMEOUT  = 2'b11
   } fault_cause_e;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_format.sv
// Combinational access formatting: legality check, store lane/byte-enable
// generation on the request side, load lane extraction on the response side.
module lsu_format
   import lsu_pkg::*;
(
   input  logic         req_we,
   input  logic [2:0]   req_funct3,
   input  logic [1:0]   req_off,
   input  logic [31:0]  req_wdata,
   output logic [3:0]   st_be,
   output logic [31:0]  st_wdata,
   output fault_cause_e chk_cause,
   input  logic [2:0]   ld_funct3,
   input  logic [1:0]   ld_off,
   input  logic [31:0]  ld_rdata,
   output logic [31:0]  ld_data
);

   logic illegal;
   logic misalign;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   always_comb begin
      illegal  = req_we ? !(req_funct3 inside {F3_B, F3_H, F3_W})
                        : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
      misalign = ((req_funct3[1:0] == 2'b01) && req_off[0]) ||
                 ((req_funct3[1:0] == 2'b10) && (req_off != 2'b00));
      if (illegal)       chk_cause = CAUSE_ILLEGAL;
      else if (misalign) chk_cause = CAUSE_MISALIGN;
      else               chk_cause = CAUSE_NONE;
   end

   always_comb begin
      case (req_funct3[1:0])
         2'b00: begin
            st_be    = 4'b0001 << req_off;
            st_wdata = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            st_be    = 4'b0011 << {req_off[1], 1'b0};
            st_wdata = {2{req_wdata[15:0]}};
         end
         default: begin
            st_be    = 4'b1111;
            st_wdata = req_wdata;
         end
      endcase
   end

   always_comb begin
      ld_byte = ld_rdata[{ld_off, 3'b000} +: 8];
      ld_half = ld_rdata[{ld_off[1], 4'b0000} +: 16];
      case (ld_funct3)
         F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
         F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
         F3_BU:   ld_data = {24'd0, ld_byte};
         F3_HU:   ld_data = {16'd0, ld_half};
         default: ld_data = ld_rdata;
      endcase
   end

endmodule

// File: rtl/lsu.sv
// Multi-cycle load/store unit: accepts one access from the core, runs the
// req/gnt/rvalid memory handshake and writes load results back to rd.
module lsu
   import lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 64,
   parameter int unsigned CNT_W       = 7
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [2:0]  req_funct3_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [4:0]  req_rd_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        rd_wren_o,
   output logic [4:0]  rd_addr_o,
   output logic [31:0] rd_data_o,
   output logic        busy_o,
   output logic        fault_o,
   output logic [1:0]  fault_cause_o
);

   lsu_state_e   state_q;
   logic [CNT_W-1:0] cnt_q;
   logic         we_q;
   logic [2:0]   funct3_q;
   logic [31:0]  addr_q;
   logic [31:0]  wdata_q;
   logic [3:0]   be_q;
   logic [4:0]   rd_q;
   logic [31:0]  rdata_q;
   logic         fault_q;
   fault_cause_e cause_q;

   logic [3:0]   st_be;
   logic [31:0]  st_wdata;
   logic [31:0]  ld_data;
   fault_cause_e chk_cause;
   logic         accept;
   logic         done_now;
   logic         timeout;

   lsu_format u_format (
      .req_we     (req_we_i),
      .req_funct3 (req_funct3_i),
      .req_off    (req_addr_i[1:0]),
      .req_wdata  (req_wdata_i),
      .st_be      (st_be),
      .st_wdata   (st_wdata),
      .chk_cause  (chk_cause),
      .ld_funct3  (funct3_q),
      .ld_off     (addr_q[1:0]),
      .ld_rdata   (mem_rdata_i),
      .ld_data    (ld_data)
   );

   assign accept   = req_valid_i && (state_q == S_IDLE);
   assign done_now = ((state_q == S_REQ) && mem_gnt_i && mem_rvalid_i) ||
                     ((state_q == S_WAIT) && mem_rvalid_i);
   assign timeout  = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk_i or posedge rst_ni) begin
      if (rst_ni) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         we_q     <= 1'b0;
         funct3_q <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         be_q     <= '0;
         rd_q     <= '0;
         rdata_q  <= '0;
         fault_q  <= 1'b0;
         cause_q  <= CAUSE_NONE;
      end else begin
         fault_q <= 1'b0;
         cause_q <= CAUSE_NONE;
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  we_q     <= req_we_i;
                  funct3_q <= req_funct3_i;
                  addr_q   <= req_addr_i;
                  wdata_q  <= st_wdata;
                  be_q     <= st_be;
                  rd_q     <= req_rd_i;
                  cnt_q    <= '0;
                  if (chk_cause == CAUSE_NONE) begin
                     state_q <= S_REQ;
                  end else begin
                     fault_q <= 1'b1;
                     cause_q <= chk_cause;
                  end
               end
            end
            S_REQ, S_WAIT: begin
               cnt_q <= cnt_q + CNT_W'(1);
               // A response landing on the final allowed cycle still completes.
               if (done_now) begin
                  state_q <= S_DONE;
                  if (!we_q) rdata_q <= ld_data;
               end else if (timeout) begin
                  state_q <= S_IDLE;
                  fault_q <= 1'b1;
                  cause_q <= CAUSE_TIMEOUT;
               end else if ((state_q == S_REQ) && mem_gnt_i) begin
                  state_q <= S_WAIT;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready_o   = (state_q == S_IDLE);
   assign busy_o        = (state_q != S_IDLE);
   assign mem_req_o     = (state_q == S_REQ);
   assign mem_we_o      = mem_req_o && we_q;
   assign mem_addr_o    = mem_req_o ? {addr_q[31:2], 2'b00} : '0;
   assign mem_be_o      = mem_req_o ? be_q : '0;
   assign mem_wdata_o   = mem_req_o ? wdata_q : '0;
   assign rd_wren_o     = (state_q == S_DONE) && !we_q && (rd_q != 5'd0);
   assign rd_addr_o     = rd_q;
   assign rd_data_o     = rdata_q;
   assign fault_o       = fault_q;
   assign fault_cause_o = cause_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed cases plus randomized accesses
// checked against an arithmetic reference of the access rules.
module tb_lsu;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        req_ready_o;
   logic        req_we_i;
   logic [2:0]  req_funct3_i;
   logic [31:0] req_addr_i;
   logic [31:0] req_wdata_i;
   logic [4:0]  req_rd_i;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [31:0] mem_addr_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_wdata_o;
   logic        mem_gnt_i;
   logic        mem_rvalid_i;
   logic [31:0] mem_rdata_i;
   logic        rd_wren_o;
   logic [4:0]  rd_addr_o;
   logic [31:0] rd_data_o;
   logic        busy_o;
   logic        fault_o;
   logic [1:0]  fault_cause_o;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk_i = ~clk_i;

   lsu #(.TIMEOUT_CYC(64), .CNT_W(7)) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_we_i      (req_we_i),
      .req_funct3_i  (req_funct3_i),
      .req_addr_i    (req_addr_i),
      .req_wdata_i   (req_wdata_i),
      .req_rd_i      (req_rd_i),
      .mem_req_o     (mem_req_o),
      .mem_we_o      (mem_we_o),
      .mem_addr_o    (mem_addr_o),
      .mem_be_o      (mem_be_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_gnt_i     (mem_gnt_i),
      .mem_rvalid_i  (mem_rvalid_i),
      .mem_rdata_i   (mem_rdata_i),
      .rd_wren_o     (rd_wren_o),
      .rd_addr_o     (rd_addr_o),
      .rd_data_o     (rd_data_o),
      .busy_o        (busy_o),
      .fault_o       (fault_o),
      .fault_cause_o (fault_cause_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // Reference model: 0 ok, 1 misaligned, 2 illegal funct3.
   function automatic int m_cause(input logic we, input int f3, input logic [31:0] addr);
      int sz;
      int off;
      sz  = f3 % 4;
      off = int'(addr % 4);
      if (we ? (f3 > 2) : (f3 == 3 || f3 == 6 || f3 == 7)) return 2;
      if ((sz == 1 && off % 2 != 0) || (sz == 2 && off != 0)) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] m_be(input int f3, input logic [31:0] addr);
      int off;
      off = int'(addr % 4);
      case (f3 % 4)
         0:       return 32'(1 << off);
         1:       return 32'(3 << off);
         default: return 32'd15;
      endcase
   endfunction

   function automatic logic [31:0] m_wdata(input int f3, input logic [31:0] w);
      case (f3 % 4)
         0:       return (w & 32'hFF) * 32'h0101_0101;
         1:       return (w & 32'hFFFF) * 32'h0001_0001;
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input int f3, input logic [31:0] addr, input logic [31:0] rdata);
      logic [31:0] v;
      logic [31:0] b;
      logic [31:0] h;
      v = rdata >> (8 * (addr % 4));
      b = v & 32'hFF;
      h = v & 32'hFFFF;
      case (f3)
         0:       return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
         1:       return (h >= 32'd32768) ? (h | 32'hFFFF_0000) : h;
         4:       return b;
         5:       return h;
         default: return rdata;
      endcase
   endfunction

   task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd);
      req_valid_i  = 1'b1;
      req_we_i     = we;
      req_funct3_i = f3;
      req_addr_i   = addr;
      req_wdata_i  = wdata;
      req_rd_i     = rd;
      step();
      req_valid_i  = 1'b0;
      req_we_i     = 1'($urandom_range(0, 1));
      req_funct3_i = 3'($urandom_range(0, 7));
      req_addr_i   = $urandom();
      req_wdata_i  = $urandom();
      req_rd_i     = 5'($urandom_range(0, 31));
   endtask

   task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd, input logic [31:0] rdata,
                         input int gnt_dly, input int rv_dly);
      int cause;
      cause = m_cause(we, int'(f3), addr);
      check("ready_idle", 32'(req_ready_o), 32'd1);
      check("busy_idle", 32'(busy_o), 32'd0);
      present(we, f3, addr, wdata, rd);
      if (cause != 0) begin
         check("fault_pulse", 32'(fault_o), 32'd1);
         check("fault_cause", 32'(fault_cause_o), 32'(cause));
         check("fault_no_req", 32'(mem_req_o), 32'd0);
         check("fault_busy", 32'(busy_o), 32'd0);
         step();
         check("fault_clear", 32'(fault_o), 32'd0);
         check("fault_no_wren", 32'(rd_wren_o), 32'd0);
         return;
      end
      for (int i = 0; i <= gnt_dly; i++) begin
         check("mem_req", 32'(mem_req_o), 32'd1);
         check("mem_addr", mem_addr_o, addr & 32'hFFFF_FFFC);
         check("mem_be", 32'(mem_be_o), m_be(int'(f3), addr));
         check("mem_we", 32'(mem_we_o), 32'(we));
         if (we) check("mem_wdata", mem_wdata_o, m_wdata(int'(f3), wdata));
         check("req_busy", 32'(busy_o), 32'd1);
         check("req_ready", 32'(req_ready_o), 32'd0);
         mem_gnt_i = (i == gnt_dly);
         // Responses without a grant must be ignored, so inject some.
         mem_rvalid_i = (i == gnt_dly) ? (rv_dly == 0) : 1'($urandom_range(0, 1));
         mem_rdata_i  = (i == gnt_dly && rv_dly == 0) ? rdata : $urandom();
         step();
      end
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      for (int j = 1; j <= rv_dly; j++) begin
         check("wait_no_req", 32'(mem_req_o), 32'd0);
         check("wait_busy", 32'(busy_o), 32'd1);
         check("wait_no_wren", 32'(rd_wren_o), 32'd0);
         mem_rvalid_i = (j == rv_dly);
         mem_rdata_i  = (j == rv_dly) ? rdata : $urandom();
         step();
      end
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = $urandom();
      check("done_wren", 32'(rd_wren_o), 32'(!we && rd != 5'd0));
      check("done_busy", 32'(busy_o), 32'd1);
      if (!we) begin
         check("done_rd_addr", 32'(rd_addr_o), 32'(rd));
         check("done_rd_data", rd_data_o, m_load(int'(f3), addr, rdata));
      end
      step();
      check("post_wren", 32'(rd_wren_o), 32'd0);
      check("post_ready", 32'(req_ready_o), 32'd1);
      check("post_fault", 32'(fault_o), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst_ni       = 1'b1;
      req_valid_i  = 1'b0;
      req_we_i     = 1'b0;
      req_funct3_i = '0;
      req_addr_i   = '0;
      req_wdata_i  = '0;
      req_rd_i     = '0;
      mem_gnt_i    = 1'b0;
      mem_rvalid_i = 1'b0;
      mem_rdata_i  = '0;
      repeat (2) @(posedge clk_i);
      #1;
      check("rst_ready", 32'(req_ready_o), 32'd1);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_mem_req", 32'(mem_req_o), 32'd0);
      check("rst_mem_be", 32'(mem_be_o), 32'd0);
      check("rst_wren", 32'(rd_wren_o), 32'd0);
      check("rst_rd_data", rd_data_o, 32'd0);
      check("rst_fault", 32'(fault_o), 32'd0);
      rst_ni = 1'b0;
      step();

      do_txn(1'b0, 3'b010, 32'h100, 32'h0, 5'd5, 32'hDEAD_BEEF, 0, 0);
      do_txn(1'b0, 3'b000, 32'h103, 32'h0, 5'd7, 32'h8011_2233, 0, 1);
      do_txn(1'b0, 3'b100, 32'h103, 32'h0, 5'd7, 32'h8011_2233, 1, 0);
      do_txn(1'b0, 3'b101, 32'h102, 32'h0, 5'd8, 32'h8011_2233, 0, 2);
      do_txn(1'b1, 3'b000, 32'h201, 32'hA5, 5'd3, 32'h0, 3, 2);
      do_txn(1'b1, 3'b001, 32'h202, 32'h1234_BEEF, 5'd0, 32'h0, 0, 0);
      do_txn(1'b0, 3'b001, 32'h101, 32'h0, 5'd4, 32'h0, 0, 0);
      do_txn(1'b0, 3'b011, 32'h100, 32'h0, 5'd4, 32'h0, 0, 0);
      do_txn(1'b1, 3'b100, 32'h101, 32'h0, 5'd4, 32'h0, 0, 0);

      // Timeout: grant on the first cycle, response never arrives.
      present(1'b0, 3'b010, 32'h300, 32'h0, 5'd9);
      n = 0;
      while (busy_o && n < 100) begin
         n++;
         mem_gnt_i    = (n == 1);
         mem_rvalid_i = 1'b0;
         step();
      end
      mem_gnt_i = 1'b0;
      check("timeout_cycles", 32'(n), 32'd64);
      check("timeout_fault", 32'(fault_o), 32'd1);
      check("timeout_cause", 32'(fault_cause_o), 32'd3);
      check("timeout_no_req", 32'(mem_req_o), 32'd0);
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = 32'hCAFE_F00D;
      step();
      mem_rvalid_i = 1'b0;
      check("late_rv_wren", 32'(rd_wren_o), 32'd0);
      check("late_rv_ready", 32'(req_ready_o), 32'd1);
      check("late_rv_fault", 32'(fault_o), 32'd0);
      step();
      check("late_rv_wren2", 32'(rd_wren_o), 32'd0);

      // Asynchronous reset while waiting for a response.
      present(1'b0, 3'b010, 32'h400, 32'h0, 5'd4);
      mem_gnt_i = 1'b1;
      step();
      mem_gnt_i = 1'b0;
      step();
      #2;
      rst_ni = 1'b1;
      #1;
      check("arst_ready", 32'(req_ready_o), 32'd1);
      check("arst_busy", 32'(busy_o), 32'd0);
      check("arst_mem_req", 32'(mem_req_o), 32'd0);
      check("arst_mem_addr", mem_addr_o, 32'd0);
      check("arst_wren", 32'(rd_wren_o), 32'd0);
      check("arst_rd_data", rd_data_o, 32'd0);
      check("arst_rd_addr", 32'(rd_addr_o), 32'd0);
      check("arst_fault", 32'(fault_o), 32'd0);
      mem_rvalid_i = 1'b1;
      @(posedge clk_i);
      #1;
      rst_ni       = 1'b0;
      mem_rvalid_i = 1'b0;
      step();
      check("arst_after_wren", 32'(rd_wren_o), 32'd0);
      do_txn(1'b0, 3'b010, 32'h104, 32'h0, 5'd0, 32'h1234_5678, 1, 1);

      for (int k = 0; k < 300; k++) begin
         do_txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom(), $urandom(),
                5'($urandom_range(0, 31)), $urandom(),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
         repeat ($urandom_range(0, 2)) step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Multi-cycle load/store unit beside the register file.
- Consumes rs1-derived address and rs2_data as store data. Produces the rd write (rd_wren/rd_addr/rd_data) for loads.
- Talks to data memory over a req/gnt/rvalid handshake.
- Asserts busy_o so the core stalls the PC while an access is in flight.

Parameters:
- TIMEOUT_CYC, 64: max cycles spent in REQ+WAIT before abort.
- CNT_W, 7: width of timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous reset, active-high (1 = reset), despite the suffix
- req_valid_i  in  1  core presents access
- req_ready_o  out  1  LSU accepts access (IDLE only)
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  RISC-V funct3 (size/sign)
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data (rs2_data)
- req_rd_i  in  5  load destination register
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_addr_o  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-aligned store data
- mem_gnt_i  in  1  request granted
- mem_rvalid_i  in  1  response valid (loads and stores)
- mem_rdata_i  in  32  read word
- rd_wren_o  out  1  regfile write enable pulse
- rd_addr_o  out  5  regfile write address
- rd_data_o  out  32  formatted load data
- busy_o  out  1  access in flight
- fault_o  out  1  one-cycle fault pulse
- fault_cause_o  out  2  01 misaligned, 10 illegal funct3, 11 timeout

Behaviour:
- Reset: state IDLE. All outputs 0, except req_ready_o = 1. Counter 0. Takes effect immediately (async), including mid-access; an in-flight access is dropped with no rd write and no fault.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - req_ready_o = 1, busy_o = 0.
  - Accept on req_valid_i & req_ready_o: register we, funct3, addr, wdata, rd.
  - Legal and aligned -> REQ.
  - Otherwise stay IDLE and, next cycle, fault_o = 1 for one cycle with the cause. No memory request, no rd write.
- Legality:
  - Illegal funct3: store 011/100/101/110/111; load 011/110/111.
  - Misaligned: half-word with addr[0] = 1, or word with addr[1:0] != 0.
  - Illegal funct3 takes priority over misaligned.
- REQ:
  - mem_req_o = 1; mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o held stable until mem_gnt_i.
  - On gnt: -> WAIT. If mem_rvalid_i is also 1 in the same cycle, -> DONE directly.
- WAIT:
  - mem_req_o = 0. On mem_rvalid_i -> DONE.
  - rvalid seen while in REQ without gnt is ignored.
- DONE (one cycle, then -> IDLE):
  - Loads: rd_wren_o = 1 only if rd != 0. rd_data_o holds formatted data captured from mem_rdata_i on the rvalid cycle.
  - Stores: no rd write.
- busy_o = 1 in REQ, WAIT, DONE. req_ready_o = 0 in those states.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - Reaching TIMEOUT_CYC -> IDLE, fault_o = 1 with cause 11, mem_req_o dropped. A late rvalid arriving afterwards is ignored.
- Store formatting:
  - SB: be = 0001 << addr[1:0], wdata = byte replicated ×4.
  - SH: be = 0011 << {addr[1],1'b0}, wdata = half replicated ×2.
  - SW: be = 1111, wdata unchanged.
- Load formatting:
  - Select byte/half lane by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Minimum latency: accept cycle 0, mem_req_o cycle 1, gnt+rvalid cycle 1, rd_wren_o cycle 2.

Decomposition:
- lsu_pkg:
  - state enum lsu_state_e
  - funct3 constants F3_B/H/W/BU/HU
  - fault cause enum (NONE/MISALIGN/ILLEGAL/TIMEOUT)
- Sub-module lsu_format (combinational):
  - store lane/byte-enable generation
  - load lane extraction and sign/zero extension
  - legality/alignment check
- The FSM, counter and registers stay in lsu.

Test Plan:
- LW addr 0x100, gnt+rvalid same cycle, rdata 0xDEADBEEF, rd = 5 -> mem_be_o = 1111; rd_wren_o = 1 at cycle 2 with rd_addr_o = 5, rd_data_o = 0xDEADBEEF.
- LB addr 0x103, rdata 0x80112233 -> rd_data_o = 0xFFFFFF80. LBU same -> 0x00000080. LHU addr 0x102 -> 0x00008011.
- SB addr 0x201, wdata 0x000000A5, gnt delayed 3 cycles -> mem_req_o/addr 0x200/be 0010/wdata 0xA5A5A5A5 held stable 4 cycles; no rd_wren_o.
- LH addr 0x101 -> no mem_req_o; fault_o = 1, cause 01. funct3 = 011 load -> cause 10. Both leave busy_o = 0.
- Load with gnt but no rvalid for 64 cycles -> fault_o cause 11, back to IDLE. A late rvalid is ignored and produces no rd write.
- rst_ni asserted while in WAIT -> outputs zero immediately, req_ready_o = 1; subsequent LW to rd = 0 completes with rd_wren_o = 0.
